traffic_light_ctrl: RTL



---
 rtl/traffic_pkg.sv | 37 +++
 rtl/tick_gen.sv | 26 ++
 rtl/traffic_light_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared traffic-light types: phase encoding, lamp bundle, default timings.
// Reused by the vehicle sequencer and the crosswalk stage.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FLASH  = 2'd3
  } phase_t;

  typedef struct packed {
    logic red;
    logic ylw;
    logic grn;
  } lamps_t;

  localparam int DEF_CLK_DIV     = 100;
  localparam int DEF_TIMER_W     = 8;
  localparam int DEF_GREEN_TIME  = 20;
  localparam int DEF_YELLOW_TIME = 4;
  localparam int DEF_RED_TIME    = 20;
  localparam int DEF_RED_MIN     = 5;

  function automatic lamps_t lamps_of(phase_t p);
    lamps_t l;
    l = '0;
    unique case (p)
      RED:    l.red = 1'b1;
      GREEN:  l.grn = 1'b1;
      YELLOW: l.ylw = 1'b1;
      FLASH:  l.ylw = 1'b1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-clk tick every CLK_DIV clocks.
// Phase is only realigned by reset.
module tick_gen #(
  parameter int CLK_DIV = 100,
  parameter int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Vehicle light sequencer RED->GREEN->YELLOW with pedestrian
// shortening of RED and a fault-driven flashing-yellow mode.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int TIMER_W     = DEF_TIMER_W,
  parameter int GREEN_TIME  = DEF_GREEN_TIME,
  parameter int YELLOW_TIME = DEF_YELLOW_TIME,
  parameter int RED_TIME    = DEF_RED_TIME,
  parameter int RED_MIN     = DEF_RED_MIN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_rqst,
  input  logic       fault,
  output logic       red_trffc_light,
  output logic       ylw_trffc_light,
  output logic       grn_trffc_light,
  output logic       ped_ack,
  output logic [1:0] phase
);

  localparam logic [TIMER_W-1:0] GRN_END =
    TIMER_W'(GREEN_TIME - 1);
  localparam logic [TIMER_W-1:0] YLW_END =
    TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] RED_END =
    TIMER_W'(RED_TIME - 1);
  localparam logic [TIMER_W-1:0] MIN_END =
    TIMER_W'(RED_MIN - 1);

  logic               tick;
  phase_t             state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic               pend, pend_nxt;
  logic               ack_nxt;
  logic               phase_end;
  logic               enter_grn;
  lamps_t             lamps, lamps_nxt;

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    phase_end = 1'b0;
    unique case (state)
      RED:    phase_end = pend ? (timer >= MIN_END)
                               : (timer == RED_END);
      GREEN:  phase_end = (timer == GRN_END);
      YELLOW: phase_end = (timer == YLW_END);
      FLASH:  phase_end = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (fault) begin
      state_nxt = FLASH;
    end else if (state == FLASH) begin
      state_nxt = RED;
    end else if (tick && phase_end) begin
      unique case (state)
        RED:    state_nxt = GREEN;
        GREEN:  state_nxt = YELLOW;
        YELLOW: state_nxt = RED;
        FLASH:  state_nxt = RED;
      endcase
    end
  end

  assign enter_grn = (state_nxt == GREEN) &&
                     (state != GREEN);

  always_comb begin
    timer_nxt = timer;
    if (fault || (state_nxt != state)) begin
      timer_nxt = '0;
    end else if (tick) begin
      timer_nxt = timer + TIMER_W'(1);
    end
  end

  // Clearing on GREEN entry beats a same-clk request.
  always_comb begin
    pend_nxt = pend;
    ack_nxt  = enter_grn && pend;
    if (fault || enter_grn) begin
      pend_nxt = 1'b0;
    end else if (ped_rqst &&
                 ((state == RED) || (state == YELLOW))) begin
      pend_nxt = 1'b1;
    end
  end

  always_comb begin
    lamps_nxt = lamps_of(state_nxt);
    if (state_nxt == FLASH) begin
      lamps_nxt.red = 1'b0;
      lamps_nxt.grn = 1'b0;
      if (state != FLASH) begin
        lamps_nxt.ylw = 1'b1;
      end else if (tick) begin
        lamps_nxt.ylw = ~lamps.ylw;
      end else begin
        lamps_nxt.ylw = lamps.ylw;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RED;
      timer   <= '0;
      pend    <= 1'b0;
      ped_ack <= 1'b0;
      lamps   <= lamps_of(RED);
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      pend    <= pend_nxt;
      ped_ack <= ack_nxt;
      lamps   <= lamps_nxt;
    end
  end

  assign red_trffc_light = lamps.red;
  assign ylw_trffc_light = lamps.ylw;
  assign grn_trffc_light = lamps.grn;
  assign phase           = state;

endmodule
